// File: rtl/mips_alu_pkg.sv
// ============================================================================
// Module : mips_alu_pkg
// Brief  : Opcode encodings, sequencer state type and negate helper shared by
//          the mips_alu_md execute-stage ALU and its multiply/divide engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_alu_pkg;

    localparam int ALU_OPW  = 5;
    // Widest value the negate helper handles; the 2*WIDTH product bounds WIDTH <= 64.
    localparam int NEG_MAXW = 128;

    localparam logic [ALU_OPW-1:0] ALU_ADD   = 5'd0;
    localparam logic [ALU_OPW-1:0] ALU_ADDU  = 5'd1;
    localparam logic [ALU_OPW-1:0] ALU_SUB   = 5'd2;
    localparam logic [ALU_OPW-1:0] ALU_SUBU  = 5'd3;
    localparam logic [ALU_OPW-1:0] ALU_AND   = 5'd4;
    localparam logic [ALU_OPW-1:0] ALU_OR    = 5'd5;
    localparam logic [ALU_OPW-1:0] ALU_XOR   = 5'd6;
    localparam logic [ALU_OPW-1:0] ALU_NOR   = 5'd7;
    localparam logic [ALU_OPW-1:0] ALU_SLT   = 5'd8;
    localparam logic [ALU_OPW-1:0] ALU_SLTU  = 5'd9;
    localparam logic [ALU_OPW-1:0] ALU_SLL   = 5'd10;
    localparam logic [ALU_OPW-1:0] ALU_SRL   = 5'd11;
    localparam logic [ALU_OPW-1:0] ALU_SRA   = 5'd12;
    localparam logic [ALU_OPW-1:0] ALU_SLLV  = 5'd13;
    localparam logic [ALU_OPW-1:0] ALU_SRLV  = 5'd14;
    localparam logic [ALU_OPW-1:0] ALU_SRAV  = 5'd15;
    localparam logic [ALU_OPW-1:0] ALU_LUI   = 5'd16;
    localparam logic [ALU_OPW-1:0] ALU_MFHI  = 5'd17;
    localparam logic [ALU_OPW-1:0] ALU_MFLO  = 5'd18;
    localparam logic [ALU_OPW-1:0] ALU_MTHI  = 5'd19;
    localparam logic [ALU_OPW-1:0] ALU_MTLO  = 5'd20;
    localparam logic [ALU_OPW-1:0] ALU_MULT  = 5'd21;
    localparam logic [ALU_OPW-1:0] ALU_MULTU = 5'd22;
    localparam logic [ALU_OPW-1:0] ALU_DIV   = 5'd23;
    localparam logic [ALU_OPW-1:0] ALU_DIVU  = 5'd24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_e;

    function automatic logic [NEG_MAXW-1:0] twos_neg(input logic [NEG_MAXW-1:0] v);
        return ~v + NEG_MAXW'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_muldiv_seq.sv
// ============================================================================
// Module : mips_muldiv_seq
// Brief  : Iterative multiply (shift-add) / divide (restoring) engine with
//          magnitude latch and sign fixup; one iteration per clock.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_muldiv_seq
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int DW = 2 * WIDTH;

    logic             running_q;
    logic [CW-1:0]    cnt_q;
    logic             div_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             dz_q;
    logic [DW-1:0]    mcand_q;
    logic [DW-1:0]    prod_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvsr_q;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_last;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [DW-1:0]    w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_a_mag = (is_signed_i && a_i[WIDTH-1]) ? WIDTH'(twos_neg(NEG_MAXW'(a_i))) : a_i;
    assign w_b_mag = (is_signed_i && b_i[WIDTH-1]) ? WIDTH'(twos_neg(NEG_MAXW'(b_i))) : b_i;

    assign w_last = (cnt_q == CW'(WIDTH));
    assign done_o = running_q && w_last;

    // Restoring step: bring in the next dividend bit, keep the subtraction if it did not borrow.
    assign w_rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, dvsr_q};
    assign w_fits   = !w_trial[WIDTH];

    // A zero divisor never borrows, so the remainder ends as |dividend| and re-signs back to lvalue.
    assign w_prod_fix = qneg_q ? DW'(twos_neg(NEG_MAXW'(prod_q))) : prod_q;
    assign w_quo_fix  = dz_q   ? '1 :
                        qneg_q ? WIDTH'(twos_neg(NEG_MAXW'(quo_q))) : quo_q;
    assign w_rem_fix  = rneg_q ? WIDTH'(twos_neg(NEG_MAXW'(rem_q))) : rem_q;

    assign hi_o = div_q ? w_rem_fix : w_prod_fix[DW-1:WIDTH];
    assign lo_o = div_q ? w_quo_fix : w_prod_fix[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
            mcand_q   <= '0;
            prod_q    <= '0;
            mplier_q  <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvsr_q    <= '0;
        end else if (start_i) begin
            running_q <= 1'b1;
            cnt_q     <= '0;
            div_q     <= is_div_i;
            qneg_q    <= is_signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            rneg_q    <= is_signed_i && a_i[WIDTH-1];
            dz_q      <= is_div_i && (b_i == '0);
            mcand_q   <= {{WIDTH{1'b0}}, w_a_mag};
            prod_q    <= '0;
            mplier_q  <= w_b_mag;
            quo_q     <= w_a_mag;
            rem_q     <= '0;
            dvsr_q    <= w_b_mag;
        end else if (running_q) begin
            if (w_last) begin
                running_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
                if (div_q) begin
                    rem_q <= w_fits ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], w_fits};
                end else begin
                    if (mplier_q[0]) begin
                        prod_q <= prod_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mips_alu_md.sv
// ============================================================================
// Module : mips_alu_md
// Brief  : EX-stage MIPS ALU with sequential multiply/divide and HI/LO.
//          Build option MIPS_ALU_OVERFLOW_EN enables signed ADD/SUB overflow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_alu_md
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int OPW   = ALU_OPW
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   aluOP,
    input  logic [WIDTH-1:0] lvalue,
    input  logic [WIDTH-1:0] rvalue,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] result_q;
    logic             out_valid_q;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_is_signed;
    logic             w_md_start;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_hi;
    logic [WIDTH-1:0] w_md_lo;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu_res;

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign w_accept    = in_valid && in_ready;
    assign w_is_mul    = (aluOP == ALU_MULT) || (aluOP == ALU_MULTU);
    assign w_is_div    = (aluOP == ALU_DIV)  || (aluOP == ALU_DIVU);
    assign w_is_signed = (aluOP == ALU_MULT) || (aluOP == ALU_DIV);
    assign w_md_start  = w_accept && (w_is_mul || w_is_div);

    assign w_sum  = lvalue + rvalue;
    assign w_diff = lvalue - rvalue;

    always_comb begin
        w_alu_res = '0;
        case (aluOP)
            ALU_ADD, ALU_ADDU: w_alu_res = w_sum;
            ALU_SUB, ALU_SUBU: w_alu_res = w_diff;
            ALU_AND:  w_alu_res = lvalue & rvalue;
            ALU_OR:   w_alu_res = lvalue | rvalue;
            ALU_XOR:  w_alu_res = lvalue ^ rvalue;
            ALU_NOR:  w_alu_res = ~(lvalue | rvalue);
            ALU_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(lvalue) < $signed(rvalue))};
            ALU_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (lvalue < rvalue)};
            ALU_SLL:  w_alu_res = rvalue << shamt;
            ALU_SRL:  w_alu_res = rvalue >> shamt;
            ALU_SRA:  w_alu_res = $signed(rvalue) >>> shamt;
            ALU_SLLV: w_alu_res = rvalue << lvalue[SHW-1:0];
            ALU_SRLV: w_alu_res = rvalue >> lvalue[SHW-1:0];
            ALU_SRAV: w_alu_res = $signed(rvalue) >>> lvalue[SHW-1:0];
            ALU_LUI:  w_alu_res = rvalue << (WIDTH/2);
            ALU_MFHI: w_alu_res = hi_q;
            ALU_MFLO: w_alu_res = lo_q;
            ALU_MTHI, ALU_MTLO: w_alu_res = lvalue;
            default:  w_alu_res = '0;
        endcase
    end

    mips_muldiv_seq #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk         (clk),
        .rst         (rst),
        .start_i     (w_md_start),
        .is_div_i    (w_is_div),
        .is_signed_i (w_is_signed),
        .a_i         (lvalue),
        .b_i         (rvalue),
        .done_o      (w_md_done),
        .hi_o        (w_md_hi),
        .lo_o        (w_md_lo)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (w_md_start) state_d = w_is_div ? DIV : MUL;
            MUL, DIV: if (w_md_done)  state_d = FIX;
            FIX:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= 1'b0;
            if (w_accept && !w_md_start) begin
                result_q    <= w_alu_res;
                out_valid_q <= 1'b1;
                if (aluOP == ALU_MTHI) hi_q <= lvalue;
                if (aluOP == ALU_MTLO) lo_q <= lvalue;
            end
            // HI/LO only change on the FIX edge, so an aborted op leaves them untouched.
            if (state_q == FIX) begin
                hi_q        <= w_md_hi;
                lo_q        <= w_md_lo;
                result_q    <= w_md_lo;
                out_valid_q <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;

`ifdef MIPS_ALU_OVERFLOW_EN
    logic overflow_q;
    logic w_ovf;

    always_comb begin
        w_ovf = 1'b0;
        if (aluOP == ALU_ADD) begin
            w_ovf = (lvalue[WIDTH-1] == rvalue[WIDTH-1]) && (w_sum[WIDTH-1] != lvalue[WIDTH-1]);
        end else if (aluOP == ALU_SUB) begin
            w_ovf = (lvalue[WIDTH-1] != rvalue[WIDTH-1]) && (w_diff[WIDTH-1] != lvalue[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= w_accept && !w_md_start && w_ovf;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_alu_md.sv
// ============================================================================
// Module : tb_mips_alu_md
// Brief  : Scoreboard bench for mips_alu_md (single-cycle ops, mul/div, reset).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_alu_md;
    import mips_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  aluOP;
    logic [31:0] lvalue;
    logic [31:0] rvalue;
    logic [4:0]  shamt;
    logic        out_valid;
    logic [31:0] result;
    logic        overflow;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] res;
        logic        ov;
        string       tag;
    } exp_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] l;
        logic [31:0] r;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        ov;
        string       tag;
    } vec_t;

    exp_t sb[$];

`ifdef MIPS_ALU_OVERFLOW_EN
    localparam logic OV_ON = 1'b1;
`else
    localparam logic OV_ON = 1'b0;
`endif

    mips_alu_md dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluOP     (aluOP),
        .lvalue    (lvalue),
        .rvalue    (rvalue),
        .shamt     (shamt),
        .out_valid (out_valid),
        .result    (result),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] l, input logic [31:0] r,
                         input logic [4:0] sh);
        in_valid = 1'b1;
        aluOP    = op;
        lvalue   = l;
        rvalue   = r;
        shamt    = sh;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic [4:0] op, input logic [31:0] l, input logic [31:0] r,
                                input logic [4:0] sh, input logic [31:0] res, input logic ov,
                                input string tag);
        vec_t v;
        v.op = op; v.l = l; v.r = r; v.sh = sh; v.res = res; v.ov = ov; v.tag = tag;
        return v;
    endfunction

    function automatic exp_t ex(input logic [31:0] res, input logic ov, input string tag);
        exp_t e;
        e.res = res; e.ov = ov; e.tag = tag;
        return e;
    endfunction

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; idle(); aluOP = '0; lvalue = '0; rvalue = '0; shamt = '0;
        step(); step();
        n_checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || overflow !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_state: ov_valid=%b result=%h overflow=%b busy=%b in_ready=%b expected 0/0/0/0/1",
                     out_valid, result, overflow, busy, in_ready);
        else n_pass++;
        rst = 1'b0;
        drive(ALU_MFHI, 0, 0, 0);
        sb.push_back(ex(32'h0, 1'b0, "reset_hi"));
        step(); idle();
        e = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || result !== e.res)
            $display("FAIL %s: valid=%b result=%h expected valid=1 result=%h", e.tag, out_valid, result, e.res);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        exp_t e;
        v.push_back(mk(ALU_ADD, 32'd5, 32'd3, 5'd0, 32'd8,         1'b0, "b2b_add"));
        v.push_back(mk(ALU_SUB, 32'd2, 32'd7, 5'd0, 32'hFFFFFFFB,  1'b0, "b2b_sub"));
        v.push_back(mk(ALU_SRA, 32'd0, 32'h80000000, 5'd4, 32'hF8000000, 1'b0, "b2b_sra"));
        foreach (v[i]) begin
            drive(v[i].op, v[i].l, v[i].r, v[i].sh);
            sb.push_back(ex(v[i].res, v[i].ov, v[i].tag));
            step();
            e = sb.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || result !== e.res || overflow !== e.ov)
                $display("FAIL %s: valid=%b result=%h ov=%b expected valid=1 result=%h ov=%b",
                         e.tag, out_valid, result, overflow, e.res, e.ov);
            else n_pass++;
        end
        idle();
        step();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL b2b_pulse_end: out_valid=%b expected 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_alu_ops();
        vec_t v[$];
        exp_t e;
        v.push_back(mk(ALU_SLT,  32'hFFFFFFFF, 32'd1, 0, 32'd1, 1'b0, "slt"));
        v.push_back(mk(ALU_SLTU, 32'hFFFFFFFF, 32'd1, 0, 32'd0, 1'b0, "sltu"));
        v.push_back(mk(ALU_MTHI, 32'h00001234, 32'd0, 0, 32'h00001234, 1'b0, "mthi"));
        v.push_back(mk(ALU_MFHI, 32'd0, 32'd0, 0, 32'h00001234, 1'b0, "mfhi"));
        v.push_back(mk(ALU_MTLO, 32'h0000ABCD, 32'd0, 0, 32'h0000ABCD, 1'b0, "mtlo"));
        v.push_back(mk(ALU_MFLO, 32'd0, 32'd0, 0, 32'h0000ABCD, 1'b0, "mflo"));
        v.push_back(mk(ALU_LUI,  32'd0, 32'h0000BEEF, 0, 32'hBEEF0000, 1'b0, "lui"));
        v.push_back(mk(ALU_NOR,  32'hF0F0F0F0, 32'h0F0F0000, 0, 32'h00000F0F, 1'b0, "nor"));
        v.push_back(mk(ALU_AND,  32'hFF00FF00, 32'h0F0F0F0F, 0, 32'h0F000F00, 1'b0, "and"));
        v.push_back(mk(ALU_OR,   32'hF0000000, 32'h0000000F, 0, 32'hF000000F, 1'b0, "or"));
        v.push_back(mk(ALU_XOR,  32'hFFFF0000, 32'hFF00FF00, 0, 32'h00FFFF00, 1'b0, "xor"));
        v.push_back(mk(ALU_SLLV, 32'd36, 32'd1, 0, 32'h00000010, 1'b0, "sllv"));
        v.push_back(mk(ALU_SRLV, 32'd31, 32'h80000000, 0, 32'h00000001, 1'b0, "srlv"));
        v.push_back(mk(ALU_SRAV, 32'd8,  32'h80000000, 0, 32'hFF800000, 1'b0, "srav"));
        v.push_back(mk(ALU_SRL,  32'd0,  32'hF0000000, 5'd28, 32'h0000000F, 1'b0, "srl"));
        v.push_back(mk(ALU_SLL,  32'd0,  32'd3, 5'd31, 32'h80000000, 1'b0, "sll"));
        v.push_back(mk(ALU_ADDU, 32'hFFFFFFFF, 32'd2, 0, 32'd1, 1'b0, "addu_wrap"));
        v.push_back(mk(ALU_SUBU, 32'd0, 32'd1, 0, 32'hFFFFFFFF, 1'b0, "subu_wrap"));
        v.push_back(mk(5'd31,    32'd1, 32'd2, 0, 32'd0, 1'b0, "unknown_op"));
        v.push_back(mk(ALU_MFHI, 32'd0, 32'd0, 0, 32'h00001234, 1'b0, "mfhi_after_unknown"));
        foreach (v[i]) begin
            drive(v[i].op, v[i].l, v[i].r, v[i].sh);
            sb.push_back(ex(v[i].res, v[i].ov, v[i].tag));
            step();
            e = sb.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || result !== e.res || overflow !== e.ov)
                $display("FAIL %s: valid=%b result=%h ov=%b expected valid=1 result=%h ov=%b",
                         e.tag, out_valid, result, overflow, e.res, e.ov);
            else n_pass++;
        end
        idle();
    endtask

    task automatic test_overflow();
        vec_t v[$];
        exp_t e;
        v.push_back(mk(ALU_ADD,  32'h7FFFFFFF, 32'd1, 0, 32'h80000000, OV_ON, "add_ovf"));
        v.push_back(mk(ALU_ADDU, 32'h7FFFFFFF, 32'd1, 0, 32'h80000000, 1'b0,  "addu_noovf"));
        v.push_back(mk(ALU_SUB,  32'h80000000, 32'd1, 0, 32'h7FFFFFFF, OV_ON, "sub_ovf"));
        v.push_back(mk(ALU_SUB,  32'd5, 32'd3, 0, 32'd2, 1'b0, "sub_noovf"));
        v.push_back(mk(ALU_ADD,  32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 1'b0, "add_neg_noovf"));
        v.push_back(mk(ALU_ADD,  32'h80000000, 32'h80000000, 0, 32'h00000000, OV_ON, "add_neg_ovf"));
        v.push_back(mk(ALU_SUBU, 32'h80000000, 32'd1, 0, 32'h7FFFFFFF, 1'b0, "subu_noovf"));
        foreach (v[i]) begin
            drive(v[i].op, v[i].l, v[i].r, v[i].sh);
            sb.push_back(ex(v[i].res, v[i].ov, v[i].tag));
            step();
            e = sb.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || result !== e.res || overflow !== e.ov)
                $display("FAIL %s: valid=%b result=%h ov=%b expected valid=1 result=%h ov=%b",
                         e.tag, out_valid, result, overflow, e.res, e.ov);
            else n_pass++;
        end
        idle();
    endtask

    task automatic test_mult_stall();
        exp_t e;
        int   lat;
        int   ready_bad;
        drive(ALU_MULT, 32'hFFFFFFFD, 32'd7, 0);
        sb.push_back(ex(32'hFFFFFFEB, 1'b0, "mult_lo"));
        step();
        lat = 0;
        ready_bad = 0;
        // Keep offering ADDs while busy; none of them may be taken.
        for (int k = 1; k <= 100; k++) begin
            in_valid = (k % 2) == 1;
            aluOP = ALU_ADD; lvalue = 32'd1; rvalue = 32'd1;
            step();
            if (out_valid === 1'b1) begin
                lat = k;
                idle();
                break;
            end
            if (in_ready !== 1'b0 || busy !== 1'b1) ready_bad++;
        end
        idle();
        n_checks++;
        if (lat != 34) $display("FAIL mult_latency: got %0d cycles expected 34", lat);
        else n_pass++;
        n_checks++;
        if (ready_bad != 0) $display("FAIL mult_stall: %0d busy cycles with in_ready high expected 0", ready_bad);
        else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if (result !== e.res || in_ready !== 1'b1)
            $display("FAIL %s: result=%h in_ready=%b expected result=%h in_ready=1", e.tag, result, in_ready, e.res);
        else n_pass++;
        drive(ALU_MFHI, 0, 0, 0);
        sb.push_back(ex(32'hFFFFFFFF, 1'b0, "mult_hi"));
        step(); idle();
        e = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || result !== e.res)
            $display("FAIL %s: valid=%b result=%h expected valid=1 result=%h", e.tag, out_valid, result, e.res);
        else n_pass++;
    endtask

    task automatic test_muldiv();
        logic [4:0]  ops[7]  = '{ALU_DIV, ALU_DIVU, ALU_DIV, ALU_MULTU, ALU_DIV, ALU_DIV, ALU_MULTU};
        logic [31:0] ls[7]   = '{32'hFFFFFFF9, 32'd10, 32'h80000000, 32'hFFFFFFFF, 32'd100, 32'hFFFFFFF9, 32'd7};
        logic [31:0] rs[7]   = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd0, 32'd9};
        logic [31:0] los[7]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h00000001, 32'hFFFFFFF2, 32'hFFFFFFFF, 32'd63};
        logic [31:0] his[7]  = '{32'hFFFFFFFF, 32'd10, 32'd0, 32'hFFFFFFFE, 32'd2, 32'hFFFFFFF9, 32'd0};
        exp_t e;
        int   lat;
        for (int i = 0; i < 7; i++) begin
            drive(ops[i], ls[i], rs[i], 0);
            sb.push_back(ex(los[i], 1'b0, $sformatf("md%0d_lo", i)));
            step(); idle();
            lat = 0;
            for (int k = 1; k <= 100; k++) begin
                step();
                if (out_valid === 1'b1) begin
                    lat = k;
                    break;
                end
            end
            e = sb.pop_front();
            n_checks++;
            if (lat != 34 || result !== e.res)
                $display("FAIL %s: latency=%0d result=%h expected latency=34 result=%h", e.tag, lat, result, e.res);
            else n_pass++;
            drive(ALU_MFHI, 0, 0, 0);
            sb.push_back(ex(his[i], 1'b0, $sformatf("md%0d_hi", i)));
            step(); idle();
            e = sb.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || result !== e.res)
                $display("FAIL %s: valid=%b result=%h expected valid=1 result=%h", e.tag, out_valid, result, e.res);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_op();
        exp_t e;
        int   stray;
        drive(ALU_MULTU, 32'd7, 32'd9, 0);
        step(); idle();
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL rst_mid_state: busy=%b in_ready=%b out_valid=%b expected 0/1/0", busy, in_ready, out_valid);
        else n_pass++;
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (out_valid !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0) $display("FAIL rst_mid_abort: %0d stray out_valid cycles expected 0", stray);
        else n_pass++;
        drive(ALU_MFLO, 0, 0, 0);
        sb.push_back(ex(32'h0, 1'b0, "rst_mid_lo"));
        step();
        e = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || result !== e.res)
            $display("FAIL %s: valid=%b result=%h expected valid=1 result=%h", e.tag, out_valid, result, e.res);
        else n_pass++;
        drive(ALU_MFHI, 0, 0, 0);
        sb.push_back(ex(32'h0, 1'b0, "rst_mid_hi"));
        step(); idle();
        e = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || result !== e.res)
            $display("FAIL %s: valid=%b result=%h expected valid=1 result=%h", e.tag, out_valid, result, e.res);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; aluOP = '0; lvalue = '0; rvalue = '0; shamt = '0;
        test_reset();
        test_back_to_back();
        test_alu_ops();
        test_overflow();
        test_mult_stall();
        test_muldiv();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
